ps2_rx_fifo: RTL

//  Parametrised PS/2 keyboard receiver, next generation of the board's PS/2 front end.

---
 rtl/ps2_rx_fifo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 deframer with E0/F0 prefix folding feeding a show-ahead FIFO
module ps2_rx_fifo #(
  parameter int FILTER_LEN    = 8,
  parameter int TIMEOUT_CYC   = 20000,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDR_W        = 3,
  parameter bit DECODE_PREFIX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2d,
  input  logic              ps2c,
  input  logic              rd_en,
  output logic [9:0]        dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err_parity,
  output logic              err_frame,
  output logic              overflow,
  output logic              busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] s1_q, s2_q, filt_q;
  logic [FW-1:0] cnt_q [2];
  logic c_prev_q;
  logic fall, d;
  state_t state_q;
  logic [2:0] bit_q;
  logic [7:0] data_q;
  logic par_q, ext_q, brk_q, err_parity_q, err_frame_q;
  logic [TW-1:0] tmo_q;
  logic in_stop, byte_ok, stop_bad, par_bad, timeout, prefix, push;
  logic [9:0] push_data;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q;
  logic [9:0] dout_q;
  logic overflow_q, we, re;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '1;
      s2_q     <= '1;
      filt_q   <= '1;
      c_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= {ps2d, ps2c};
      s2_q     <= s1_q;
      c_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          cnt_q[i]  <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  assign fall = c_prev_q & ~filt_q[0];
  assign d    = filt_q[1];
  always_comb begin
    in_stop   = fall && state_q == STOP;
    byte_ok   = in_stop && d && ^{data_q, par_q};
    stop_bad  = in_stop && !d;
    par_bad   = in_stop && d && !(^{data_q, par_q});
    timeout   = state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1);
    prefix    = DECODE_PREFIX && (data_q == 8'hE0 || data_q == 8'hF0);
    push      = byte_ok && !prefix;
    push_data = DECODE_PREFIX ? {ext_q, brk_q, data_q} : {2'b00, data_q};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      err_parity_q <= par_bad;
      err_frame_q  <= stop_bad | timeout;
      tmo_q        <= (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;
      if (timeout) state_q <= IDLE;
      else if (fall) begin
        case (state_q)
          IDLE: if (!d) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
          DATA: begin
            data_q  <= {d, data_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            state_q <= bit_q == 3'd7 ? PARITY : DATA;
          end
          PARITY: begin
            par_q   <= d;
            state_q <= STOP;
          end
          STOP: state_q <= IDLE;
        endcase
      end
      if (par_bad || stop_bad || timeout) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_ok && DECODE_PREFIX) begin
        ext_q <= data_q == 8'hE0 ? 1'b1 : (data_q == 8'hF0 ? ext_q : 1'b0);
        brk_q <= data_q == 8'hF0 ? 1'b1 : (data_q == 8'hE0 ? brk_q : 1'b0);
      end
    end
  end
  assign empty    = count_q == '0;
  assign full     = count_q == (ADDR_W + 1)'(FIFO_DEPTH);
  assign we       = push & (~full | rd_en);
  assign re       = rd_en & ~empty;
  assign rd_ptr_d = rd_ptr_q + ADDR_W'(re);
  // head register looks ahead at the post-edge pointer so back-to-back pops see fresh data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (we) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q   <= wr_ptr_q + ADDR_W'(we);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_q + (ADDR_W + 1)'(we) - (ADDR_W + 1)'(re);
      dout_q     <= (we && wr_ptr_q == rd_ptr_d) ? push_data : mem_q[rd_ptr_d];
      overflow_q <= push & full & ~rd_en;
    end
  end
  assign dout       = dout_q;
  assign count      = count_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overflow   = overflow_q;
  assign busy       = state_q != IDLE;
endmodule
